// File: rtl/rs_encode_pkg.sv
// Shared types and GF(2^m) helpers for the streaming RS encoder.
// Generator taps are derived at elaboration time from the code parameters.
package rs_encode_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MSG,
    PARITY
  } state_e;

  localparam int MAX_SYM_W = 12;
  localparam int MAX_NSYM  = 32;

  function automatic int unsigned gf_mul(
    input int unsigned a,
    input int unsigned b,
    input int          sym_w,
    input int unsigned prim_poly
  );
    int unsigned p;
    int unsigned x;
    p = 0;
    x = a;
    for (int i = 0; i < sym_w; i++) begin
      if (b[i]) p = p ^ x;
      x = x << 1;
      if (x[sym_w]) x = x ^ prim_poly;
    end
    return p;
  endfunction

  // Coefficient j of x^j, monic term dropped.
  function automatic logic [MAX_NSYM*MAX_SYM_W-1:0] gen_poly(
    input int          nsym,
    input int          sym_w,
    input int unsigned prim_poly,
    input int          fcr
  );
    int unsigned g [MAX_NSYM+1];
    int unsigned root;
    logic [MAX_NSYM*MAX_SYM_W-1:0] res;
    for (int k = 0; k <= MAX_NSYM; k++) g[k] = 0;
    g[0] = 1;
    root = 1;
    for (int i = 0; i < fcr; i++)
      root = gf_mul(root, 2, sym_w, prim_poly);
    for (int i = 0; i < nsym; i++) begin
      for (int j = nsym; j > 0; j--)
        g[j] = g[j-1] ^ gf_mul(g[j], root, sym_w, prim_poly);
      g[0] = gf_mul(g[0], root, sym_w, prim_poly);
      root = gf_mul(root, 2, sym_w, prim_poly);
    end
    res = '0;
    for (int j = 0; j < nsym; j++)
      res[j*MAX_SYM_W +: MAX_SYM_W] = MAX_SYM_W'(g[j]);
    return res;
  endfunction

endpackage

// File: rtl/rs_gf_cmul.sv
// Constant GF(2^m) multiplier: y = COEF * a as a fixed XOR matrix.
// Column i holds COEF * x^i, selected by bit i of the operand.
module rs_gf_cmul
  import rs_encode_pkg::*;
#(
  parameter int               SYM_W     = 8,
  parameter int unsigned      PRIM_POLY = 'h11D,
  parameter logic [SYM_W-1:0] COEF      = '0
) (
  input  logic [SYM_W-1:0] a,
  output logic [SYM_W-1:0] y
);

  logic [SYM_W-1:0] col [SYM_W];

  for (genvar i = 0; i < SYM_W; i++) begin : g_col
    localparam logic [SYM_W-1:0] C =
      SYM_W'(gf_mul(32'(COEF), 32'(1) << i,
                    SYM_W, PRIM_POLY));
    assign col[i] = a[i] ? C : '0;
  end

  always_comb begin
    y = '0;
    for (int i = 0; i < SYM_W; i++)
      y = y ^ col[i];
  end

endmodule

// File: rtl/rs_encode_stream.sv
// Streaming systematic Reed-Solomon encoder with valid/ready on both sides.
// Message symbols pass through; NSYM parity symbols follow each block.
module rs_encode_stream
  import rs_encode_pkg::*;
#(
  parameter int          SYM_W     = 8,
  parameter int          NSYM      = 4,
  parameter int          MAX_K     = 251,
  parameter int unsigned PRIM_POLY = 'h11D,
  parameter int          FCR       = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [SYM_W-1:0] s_data_i,
  input  logic             s_last_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [SYM_W-1:0] m_data_o,
  output logic             m_parity_o,
  output logic             m_last_o,
  output logic             err_overrun_o,
  output logic             busy_o
);

  localparam logic [MAX_NSYM*MAX_SYM_W-1:0] GP =
    gen_poly(NSYM, SYM_W, PRIM_POLY, FCR);
  localparam int CW = $clog2(MAX_K + 1);
  localparam int PW = $clog2(NSYM);

  state_e           state;
  state_e           state_d;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic [PW-1:0]    pidx;
  logic [SYM_W-1:0] r    [NSYM];
  logic [SYM_W-1:0] prod [NSYM];
  logic [SYM_W-1:0] fb;
  logic             load_en;
  logic             accept;
  logic             hit_max;
  logic             par_last;

  assign fb = s_data_i ^ r[NSYM-1];

  for (genvar j = 0; j < NSYM; j++) begin : g_tap
    rs_gf_cmul #(
      .SYM_W    (SYM_W),
      .PRIM_POLY(PRIM_POLY),
      .COEF     (GP[j*MAX_SYM_W +: SYM_W])
    ) u_cmul (
      .a(fb),
      .y(prod[j])
    );
  end

  assign load_en  = !m_valid_o || m_ready_i;
  assign s_ready_o = !rst_i && !clr_i &&
                     (state != PARITY) && load_en;
  assign accept   = s_valid_i && s_ready_o;
  assign count_next = (state == IDLE) ? CW'(1)
                                      : count + CW'(1);
  assign hit_max  = (count_next == CW'(MAX_K));
  assign par_last = (pidx == PW'(NSYM - 1));
  assign busy_o   = (state != IDLE) || m_valid_o;
  assign err_overrun_o = accept && !s_last_i && hit_max;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, MSG: begin
        if (accept && (s_last_i || hit_max))
          state_d = PARITY;
        else if (accept)
          state_d = MSG;
      end
      PARITY: begin
        if (load_en && par_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clr_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count      <= '0;
      pidx       <= '0;
      m_valid_o  <= 1'b0;
      m_data_o   <= '0;
      m_parity_o <= 1'b0;
      m_last_o   <= 1'b0;
      for (int j = 0; j < NSYM; j++) r[j] <= '0;
    end else if (clr_i) begin
      count      <= '0;
      pidx       <= '0;
      m_valid_o  <= 1'b0;
      m_parity_o <= 1'b0;
      m_last_o   <= 1'b0;
      for (int j = 0; j < NSYM; j++) r[j] <= '0;
    end else if (accept) begin
      m_valid_o  <= 1'b1;
      m_data_o   <= s_data_i;
      m_parity_o <= 1'b0;
      m_last_o   <= 1'b0;
      r[0] <= prod[0];
      for (int j = 1; j < NSYM; j++)
        r[j] <= r[j-1] ^ prod[j];
      count <= (s_last_i || hit_max) ? '0 : count_next;
    end else if (state == PARITY && load_en) begin
      // Shifting zeros in leaves the LFSR cleared for the next block.
      m_valid_o  <= 1'b1;
      m_data_o   <= r[NSYM-1];
      m_parity_o <= 1'b1;
      m_last_o   <= par_last;
      r[0] <= '0;
      for (int j = 1; j < NSYM; j++)
        r[j] <= r[j-1];
      pidx <= par_last ? '0 : pidx + PW'(1);
    end else if (m_ready_i) begin
      m_valid_o  <= 1'b0;
      m_parity_o <= 1'b0;
      m_last_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rs_encode_stream.sv
// Directed bench for rs_encode_stream, RS(255,251) over GF(256) 0x11D.
// Expected codewords come from constants or a long-division model.
module tb_rs_encode_stream;

  logic       clk = 1'b0;
  logic       rst, clr, s_valid, s_ready, s_last;
  logic [7:0] s_data, m_data;
  logic       m_valid, m_ready, m_parity, m_last;
  logic       err_ovr, busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] out_q [$];
  logic [9:0] exp_q [$];
  logic [8:0] tx_q  [$];
  logic [7:0] msg_q [$];
  logic [7:0] gtab  [5] = '{8'h01, 8'h0f, 8'h36, 8'h78, 8'h40};
  int ovr_cnt, ovr_at, hs_first, hs_last, hs_cnt;

  always #5 clk = ~clk;

  rs_encode_stream dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .clr_i        (clr),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready),
    .s_data_i     (s_data),
    .s_last_i     (s_last),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .m_data_o     (m_data),
    .m_parity_o   (m_parity),
    .m_last_o     (m_last),
    .err_overrun_o(err_ovr),
    .busy_o       (busy)
  );

  always @(negedge clk)
    if (m_valid && m_ready)
      out_q.push_back({m_last, m_parity, m_data});

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p, x;
    logic       cy;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      cy = x[7];
      x  = x << 1;
      if (cy) x = x ^ 8'h1D;
    end
    return p;
  endfunction

  // Remainder of m(x)*x^4 by g(x), via long division.
  task automatic make_exp(input logic [7:0] msg [$]);
    logic [7:0] b [$];
    logic [7:0] c;
    int k;
    k = msg.size();
    b = msg;
    repeat (4) b.push_back(8'h00);
    for (int i = 0; i < k; i++) begin
      c = b[i];
      for (int j = 1; j < 5; j++)
        b[i+j] = b[i+j] ^ gmul(c, gtab[j]);
    end
    exp_q.delete();
    for (int i = 0; i < k; i++)
      exp_q.push_back({2'b00, msg[i]});
    for (int p = 0; p < 4; p++)
      exp_q.push_back({p == 3, 1'b1, b[k+p]});
  endtask

  task automatic run(input int rmode, input int max_cyc);
    int i, n, c;
    bit held_v, in_par, got_last, done;
    logic [9:0] held;
    i = 0; n = tx_q.size();
    held_v = 0; in_par = 0; got_last = 0; done = 0;
    held = '0;
    ovr_cnt = 0; ovr_at = -1;
    hs_cnt = 0; hs_first = -1; hs_last = -1;
    for (c = 0; c < max_cyc && !done; c++) begin
      @(posedge clk); #1;
      m_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      s_valid = (i < n);
      {s_last, s_data} = (i < n) ? tx_q[i] : 9'h000;
      @(negedge clk);
      if (m_valid && m_last) in_par = 0;
      if (rmode != 0) begin
        if (held_v) begin
          n_cmp++;
          if ({m_valid, m_last, m_parity, m_data} !== {1'b1, held}) begin
            n_err++;
            $display("FAIL stall_hold cyc %0d: got %b_%h want 1_%h",
                     c, m_valid, {m_last, m_parity, m_data}, held);
          end
        end
        if (in_par) begin
          n_cmp++;
          if (s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ready_in_parity cyc %0d: got %b want 0",
                     c, s_ready);
          end
        end
      end
      held_v = m_valid && !m_ready;
      held   = {m_last, m_parity, m_data};
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = c;
        hs_last = c;
        if (m_last) got_last = 1;
      end
      if (err_ovr) begin
        ovr_cnt++;
        ovr_at = i;
        in_par = 1;
      end
      if (s_valid && s_ready) begin
        if (s_last) in_par = 1;
        i++;
      end
      done = (i == n) && got_last && !m_valid;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL run_timeout: sent %0d of %0d in %0d cycles",
               i, n, max_cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({s_ready, m_valid, m_data, m_parity, m_last, err_ovr, busy}
        !== 14'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 0",
               {s_ready, m_valid, m_data, m_parity, m_last, err_ovr, busy});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({s_ready, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL idle_after_reset: got %b want 10", {s_ready, busy});
    end
  endtask

  task automatic test_single();
    logic [9:0] e [5];
    e = '{10'h001, 10'h10f, 10'h136, 10'h178, 10'h340};
    out_q.delete();
    tx_q = '{9'h101};
    run(0, 50);
    n_cmp++;
    if (out_q.size() != 5) begin
      n_err++;
      $display("FAIL single_len: got %0d want 5", out_q.size());
    end
    for (int k = 0; k < 5 && k < out_q.size(); k++) begin
      n_cmp++;
      if (out_q[k] !== e[k]) begin
        n_err++;
        $display("FAIL single_sym %0d: got %h want %h", k, out_q[k], e[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] e [17];
    e = '{10'h002, 10'h11e, 10'h16c, 10'h1f0, 10'h380,
          10'h000, 10'h000, 10'h000,
          10'h100, 10'h100, 10'h100, 10'h300,
          10'h001, 10'h10f, 10'h136, 10'h178, 10'h340};
    out_q.delete();
    tx_q = '{9'h102, 9'h000, 9'h000, 9'h100, 9'h101};
    run(0, 80);
    n_cmp++;
    if (out_q.size() != 17) begin
      n_err++;
      $display("FAIL b2b_len: got %0d want 17", out_q.size());
    end
    for (int k = 0; k < 17 && k < out_q.size(); k++) begin
      n_cmp++;
      if (out_q[k] !== e[k]) begin
        n_err++;
        $display("FAIL b2b_sym %0d: got %h want %h", k, out_q[k], e[k]);
      end
    end
    n_cmp++;
    if (hs_last - hs_first + 1 != 17 || hs_cnt != 17) begin
      n_err++;
      $display("FAIL b2b_gapless: got span %0d cnt %0d want 17",
               hs_last - hs_first + 1, hs_cnt);
    end
  endtask

  task automatic test_full_block(input int rmode);
    logic [7:0] s, x;
    msg_q.delete();
    for (int k = 0; k < 251; k++)
      msg_q.push_back(8'((k * 37 + 11) ^ (k >> 3)));
    make_exp(msg_q);
    tx_q.delete();
    for (int k = 0; k < 251; k++)
      tx_q.push_back({k == 250, msg_q[k]});
    out_q.delete();
    run(rmode, 3000);
    n_cmp++;
    if (out_q.size() != 255 || ovr_cnt != 0) begin
      n_err++;
      $display("FAIL full_len m%0d: got %0d ovr %0d want 255 ovr 0",
               rmode, out_q.size(), ovr_cnt);
    end
    for (int k = 0; k < 255 && k < out_q.size(); k++) begin
      n_cmp++;
      if (out_q[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL full_sym m%0d %0d: got %h want %h",
                 rmode, k, out_q[k], exp_q[k]);
      end
    end
    for (int a = 0; a < 4; a++) begin
      x = 8'(1 << a);
      s = 8'h00;
      for (int k = 0; k < out_q.size(); k++)
        s = gmul(s, x) ^ out_q[k][7:0];
      n_cmp++;
      if (s !== 8'h00) begin
        n_err++;
        $display("FAIL syndrome m%0d a^%0d: got %h want 00", rmode, a, s);
      end
    end
  endtask

  task automatic test_overrun();
    msg_q.delete();
    for (int k = 0; k < 252; k++)
      msg_q.push_back(8'(k * 5 + 3));
    tx_q.delete();
    for (int k = 0; k < 252; k++)
      tx_q.push_back({1'b0, msg_q[k]});
    void'(msg_q.pop_back());
    make_exp(msg_q);
    exp_q.push_back({2'b00, 8'(251 * 5 + 3)});
    out_q.delete();
    run(0, 400);
    n_cmp++;
    if (ovr_cnt != 1 || ovr_at != 250) begin
      n_err++;
      $display("FAIL overrun_pulse: got cnt %0d at %0d want 1 at 250",
               ovr_cnt, ovr_at);
    end
    n_cmp++;
    if (out_q.size() != 256) begin
      n_err++;
      $display("FAIL overrun_len: got %0d want 256", out_q.size());
    end
    for (int k = 0; k < 256 && k < out_q.size(); k++) begin
      n_cmp++;
      if (out_q[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL overrun_sym %0d: got %h want %h",
                 k, out_q[k], exp_q[k]);
      end
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_newblk_busy: got %b want 1", busy);
    end
    @(posedge clk); #1; clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_clr_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_abort(input bit use_rst);
    logic [9:0] e [5];
    e = '{10'h001, 10'h10f, 10'h136, 10'h178, 10'h340};
    @(posedge clk); #1;
    m_ready = 1'b1; s_valid = 1'b1; {s_last, s_data} = 9'h101;
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    if (use_rst) rst = 1'b1;
    else         clr = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; clr = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({m_valid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL abort_r%0d: got valid/busy %b want 00",
               use_rst, {m_valid, busy});
    end
    out_q.delete();
    tx_q = '{9'h101};
    run(0, 50);
    n_cmp++;
    if (out_q.size() != 5) begin
      n_err++;
      $display("FAIL abort_len_r%0d: got %0d want 5",
               use_rst, out_q.size());
    end
    for (int k = 0; k < 5 && k < out_q.size(); k++) begin
      n_cmp++;
      if (out_q[k] !== e[k]) begin
        n_err++;
        $display("FAIL abort_sym_r%0d %0d: got %h want %h",
                 use_rst, k, out_q[k], e[k]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    m_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_full_block(0);
    test_full_block(1);
    test_overrun();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
